core_if: RTL and testbench

CORE_IF -- requirements
Module: core_if

---
 rtl/core_if.sv | 231 +++++++++++++++++++++++
 tb/tb_core_if.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_if.sv
// Instruction fetch front end: one request at a time to instruction memory,
// registered hand-off of fetched words to decode, branch redirect and fault stop.
// Optional feature macro: CORE_IF_PREFETCH_EN (one-entry buffer for acks that
// land while decode is halted). Undefined by default.
module core_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_halt,
    input  logic        if_flush,
    input  logic        branch,
    input  logic [31:0] branch_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_data,
    input  logic        im_err,
    output logic [31:0] if_ins,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        if_err
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INS_LEN = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_e;

    state_e            state_q,    state_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic              im_req_q,   im_req_d;
    logic [XLEN-1:0]   im_addr_q,  im_addr_d;
    logic [XLEN-1:0]   if_ins_q,   if_ins_d;
    logic [XLEN-1:0]   if_pc_q,    if_pc_d;
    logic              if_valid_q, if_valid_d;
    logic              if_err_q,   if_err_d;
    logic              redir_q,    redir_d;
`ifdef CORE_IF_PREFETCH_EN
    logic              buf_valid_q, buf_valid_d;
    logic [XLEN-1:0]   buf_ins_q,   buf_ins_d;
    logic [XLEN-1:0]   buf_pc_q,    buf_pc_d;
`endif

    logic              ack_c;
    logic [XLEN-1:0]   target_pc_c;
    logic [XLEN-1:0]   pc_inc_c;

    // An ack only counts while our own request is on the bus
    assign ack_c       = im_req_q & im_ack;
    // Address for the next request: a redirect this cycle wins
    assign target_pc_c = branch ? branch_pc : pc_q;
    assign pc_inc_c    = pc_q + XLEN'(INS_LEN);

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        im_req_d   = im_req_q;
        im_addr_d  = im_addr_q;
        if_ins_d   = if_ins_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        if_err_d   = if_err_q;
        redir_d    = redir_q;
`ifdef CORE_IF_PREFETCH_EN
        buf_valid_d = buf_valid_q;
        buf_ins_d   = buf_ins_q;
        buf_pc_d    = buf_pc_q;
`endif

        unique case (state_q)
            IDLE: begin
                pc_d = target_pc_c;
                if (branch) begin
                    if_valid_d = 1'b0;
                end
                if (if_halt) begin
                    state_d = HOLD;
                end else begin
                    state_d   = REQ;
                    im_req_d  = 1'b1;
                    im_addr_d = target_pc_c;
                end
            end

            REQ: begin
                if (ack_c) begin
                    if (redir_q || branch) begin
                        // Wrong-path word: drop it and restart at the redirect target
                        redir_d    = 1'b0;
                        pc_d       = target_pc_c;
                        if_valid_d = 1'b0;
                        if (if_halt) begin
                            state_d  = HOLD;
                            im_req_d = 1'b0;
                        end else begin
                            im_req_d  = 1'b1;
                            im_addr_d = target_pc_c;
                        end
                    end else if (im_err) begin
                        state_d    = ERR;
                        if_err_d   = 1'b1;
                        if_valid_d = 1'b0;
                        im_req_d   = 1'b0;
                    end else if (if_halt) begin
                        state_d  = HOLD;
                        im_req_d = 1'b0;
`ifdef CORE_IF_PREFETCH_EN
                        buf_valid_d = 1'b1;
                        buf_ins_d   = im_data;
                        buf_pc_d    = im_addr_q;
                        pc_d        = pc_inc_c;
`endif
                    end else begin
                        if_ins_d   = im_data;
                        if_pc_d    = im_addr_q;
                        if_valid_d = 1'b1;
                        pc_d       = pc_inc_c;
                        im_req_d   = 1'b1;
                        im_addr_d  = pc_inc_c;
                    end
                end else if (branch) begin
                    // Request still on the bus: keep it stable, remember the redirect
                    redir_d    = 1'b1;
                    pc_d       = branch_pc;
                    if_valid_d = 1'b0;
                end else if (!if_halt) begin
                    if_valid_d = 1'b0;
                end
            end

            HOLD: begin
                pc_d = target_pc_c;
                if (branch) begin
                    if_valid_d = 1'b0;
`ifdef CORE_IF_PREFETCH_EN
                    buf_valid_d = 1'b0;
`endif
                end
                if (!if_halt) begin
                    state_d    = REQ;
                    im_req_d   = 1'b1;
                    im_addr_d  = target_pc_c;
                    if_valid_d = 1'b0;
`ifdef CORE_IF_PREFETCH_EN
                    if (buf_valid_q && !branch) begin
                        if_ins_d    = buf_ins_q;
                        if_pc_d     = buf_pc_q;
                        if_valid_d  = 1'b1;
                        buf_valid_d = 1'b0;
                    end
`endif
                end
            end

            ERR: begin
                if (branch) begin
                    if_err_d   = 1'b0;
                    if_valid_d = 1'b0;
                    pc_d       = branch_pc;
                    if (if_halt) begin
                        state_d = HOLD;
                    end else begin
                        state_d   = REQ;
                        im_req_d  = 1'b1;
                        im_addr_d = branch_pc;
                    end
                end
            end
        endcase

        // Flush squashes whatever decode would see next cycle
        if (if_flush) begin
            if_valid_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            im_req_q   <= 1'b0;
            im_addr_q  <= RESET_PC;
            if_ins_q   <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            if_err_q   <= 1'b0;
            redir_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            im_req_q   <= im_req_d;
            im_addr_q  <= im_addr_d;
            if_ins_q   <= if_ins_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            if_err_q   <= if_err_d;
            redir_q    <= redir_d;
        end
    end

`ifdef CORE_IF_PREFETCH_EN
    // Prefetch buffer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_ins_q   <= '0;
            buf_pc_q    <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_ins_q   <= buf_ins_d;
            buf_pc_q    <= buf_pc_d;
        end
    end
`endif

    assign im_req   = im_req_q;
    assign im_addr  = im_addr_q;
    assign if_ins   = if_ins_q;
    assign if_pc    = if_pc_q;
    assign if_valid = if_valid_q;
    assign if_err   = if_err_q;

endmodule

// File: tb/tb_core_if.sv
// Bench for core_if: directed scenarios then random traffic, each cycle checked
// against a transaction-level fetch model.
module tb_core_if;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        if_halt;
    logic        if_flush;
    logic        branch;
    logic [31:0] branch_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_data;
    logic        im_err;
    logic [31:0] if_ins;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        if_err;

    int n_cmp = 0;
    int n_bad = 0;

    core_if #(.RESET_PC(RPC)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_halt  (if_halt),
        .if_flush (if_flush),
        .branch   (branch),
        .branch_pc(branch_pc),
        .im_req   (im_req),
        .im_addr  (im_addr),
        .im_ack   (im_ack),
        .im_data  (im_data),
        .im_err   (im_err),
        .if_ins   (if_ins),
        .if_pc    (if_pc),
        .if_valid (if_valid),
        .if_err   (if_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch model: phase 0 = waiting after reset, 1 = fetching, 2 = parked, 3 = faulted
    int          m_ph;
    bit          m_out;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_ins;
    logic [31:0] m_ipc;
    bit          m_v;
    bit          m_e;
    bit          m_bv;
    logic [31:0] m_bd;
    logic [31:0] m_bp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_out = 0; m_addr = RPC; m_pc = RPC; m_pend = 0;
        m_ins = '0; m_ipc = '0; m_v = 0; m_e = 0; m_bv = 0; m_bd = '0; m_bp = '0;
    endtask

    task automatic deliver(input logic [31:0] word, input logic [31:0] addr);
        m_ins = word; m_ipc = addr; m_v = 1;
    endtask

    task automatic model_step(input bit h, input bit f, input bit b, input logic [31:0] bp,
                              input bit a, input logic [31:0] d, input bit e);
        case (m_ph)
            0: begin
                if (b) begin m_pc = bp; m_v = 0; end
                m_ph = h ? 2 : 1;
            end
            1: begin
                if (m_out && a) begin
                    m_out = 0;
                    if (m_pend || b) begin
                        if (b) m_pc = bp;
                        m_pend = 0; m_v = 0;
                        if (h) m_ph = 2;
                    end else if (e) begin
                        m_e = 1; m_v = 0; m_ph = 3;
                    end else if (h) begin
`ifdef CORE_IF_PREFETCH_EN
                        m_bv = 1; m_bd = d; m_bp = m_addr; m_pc = m_addr + 32'd4;
`endif
                        m_ph = 2;
                    end else begin
                        deliver(d, m_addr);
                        m_pc = m_addr + 32'd4;
                    end
                end else if (b) begin
                    m_pend = 1; m_pc = bp; m_v = 0;
                end else if (!h) begin
                    m_v = 0;
                end
            end
            2: begin
                if (b) begin m_pc = bp; m_v = 0; m_bv = 0; end
                if (!h) begin
                    m_ph = 1;
                    if (m_bv) begin deliver(m_bd, m_bp); m_bv = 0; end
                    else m_v = 0;
                end
            end
            default: begin
                if (b) begin
                    m_e = 0; m_pc = bp; m_v = 0;
                    m_ph = h ? 2 : 1;
                end
            end
        endcase
        if (f) m_v = 0;
        if (m_ph == 1 && !m_out) begin
            m_out = 1; m_addr = m_pc;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("im_req", 32'(im_req), 32'(m_out));
        if (m_out) chk("im_addr", im_addr, m_addr);
        chk("if_valid", 32'(if_valid), 32'(m_v));
        chk("if_err", 32'(if_err), 32'(m_e));
        if (m_v) begin
            chk("if_ins", if_ins, m_ins);
            chk("if_pc", if_pc, m_ipc);
        end
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at the next fall
    task automatic step(input bit h, input bit f, input bit b, input logic [31:0] bp,
                        input bit a, input bit e);
        logic [31:0] d;
        d = mem_word(im_addr);
        if_halt = h; if_flush = f; branch = b; branch_pc = bp;
        im_ack = a; im_data = d; im_err = e;
        @(posedge clk);
        model_step(h, f, b, bp, a, d, e);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_values();
        chk("rst_im_req", 32'(im_req), 32'd0);
        chk("rst_im_addr", im_addr, RPC);
        chk("rst_if_ins", if_ins, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_err", 32'(if_err), 32'd0);
    endtask

    initial begin
        rst = 1'b0; if_halt = 0; if_flush = 0; branch = 0; branch_pc = '0;
        im_ack = 0; im_data = '0; im_err = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b1;

        // Reset release: one idle cycle, then zero-wait fetch 0x100..0x108
        step(0, 0, 0, '0, 0, 0);
        chk("first_addr", im_addr, 32'h100);
        repeat (3) step(0, 0, 0, '0, 1, 0);
        chk("addr_10c", im_addr, 32'h10C);
        chk("pc_108", if_pc, 32'h108);

        // Redirect while 0x10C is outstanding: its ack is dropped
        step(0, 0, 1, 32'h2000, 0, 0);
        step(0, 0, 0, '0, 1, 0);
        chk("redir_addr", im_addr, 32'h2000);
        chk("redir_valid", 32'(if_valid), 32'd0);

        // Two wait states per fetch
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, '0, 0, 0);
            step(0, 0, 0, '0, 0, 0);
            step(0, 0, 0, '0, 1, 0);
        end

        // Halt for three cycles with a request in flight
        step(0, 0, 0, '0, 0, 0);
        step(1, 0, 0, '0, 0, 0);
        step(1, 0, 0, '0, 1, 0);
        step(1, 0, 0, '0, 0, 0);
        step(0, 0, 0, '0, 0, 0);
        repeat (3) step(0, 0, 0, '0, 1, 0);

        // Bus error at 0x200, parked until redirect to 0x300
        step(0, 0, 1, 32'h200, 0, 0);
        step(0, 0, 0, '0, 1, 0);
        chk("err_fetch_addr", im_addr, 32'h200);
        step(0, 0, 0, '0, 1, 1);
        chk("err_set", 32'(if_err), 32'd1);
        step(0, 0, 0, '0, 1, 0);
        step(0, 0, 0, '0, 1, 1);
        chk("err_no_req", 32'(im_req), 32'd0);
        step(0, 0, 1, 32'h300, 0, 0);
        chk("err_clear", 32'(if_err), 32'd0);
        chk("err_redir_addr", im_addr, 32'h300);

        // Flush, and pc wrap at the top of the address space
        step(0, 0, 0, '0, 1, 0);
        step(0, 1, 0, '0, 1, 0);
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, '0, 1, 0);
        step(0, 0, 0, '0, 1, 0);
        chk("wrap_addr", im_addr, 32'h0);

        // Asynchronous reset mid-request, late ack after release is ignored
        step(0, 0, 0, '0, 0, 0);
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, '0, 1, 0);
        repeat (3) step(0, 0, 0, '0, 1, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bp;
            bp = $urandom() & 32'hFFFF_FFFC;
            step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 8, bp,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
